conv_layer_stream: RTL and testbench

Parametrised, stride-capable 2-D convolution layer for the MNIST inference pipeline. It is the general successor to the fixed second convolution stage. It takes image, weights and biases over one valid/ready input stream into internal RAMs. It then computes every output pixel with a single pipelined MAC, applies bias, fixed-point rescale, optional ReLU and saturation, and emits the feature map over a valid/ready output stream. It sits between the previous layer (or pooling stage) and the next layer or dense block.

---
 rtl/conv_layer_stream.sv | 355 +++++++++++++++++++++++++++++++++++
 tb/tb_conv_layer_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_stream.sv
// -----------------------------------------------------------------------------
// conv_layer_stream
//
// Purpose: stride-capable 2-D convolution layer. One input stream loads the
// image, then the weights, then the biases into internal RAMs. A single
// pipelined MAC then computes every output pixel. Each result gets bias,
// fixed-point rescale, optional ReLU and saturation, and leaves on an output
// stream in filter, row, col order.
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where valid && ready are both high. A source never withdraws or alters a
// beat while valid is high and ready is low.
//
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   start      in   one-cycle pulse, starts a run from IDLE (ignored otherwise)
//   in_valid   in   input beat valid
//   in_ready   out  high only while loading
//   in_data    in   input beat (image, weights, biases)
//   out_valid  out  feature-map sample valid
//   out_ready  in   downstream accepts sample
//   out_data   out  feature-map sample
//   out_last   out  high with the final sample of the map
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last sample is accepted
//   dbg_state  out  current FSM state (0 IDLE, 1 LOAD, 2 COMPUTE, 3 DONE)
// -----------------------------------------------------------------------------
module conv_layer_stream #(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 3,
    parameter int IN_IMG_SIZE  = 12,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 13,
    parameter int ACC_WIDTH    = 40,
    parameter int RELU_EN      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OUT_IMG_SIZE = (IN_IMG_SIZE - KERNEL_SIZE) / STRIDE + 1;
    localparam int IMG_N  = IN_CHANNELS * IN_IMG_SIZE * IN_IMG_SIZE;
    localparam int WGT_N  = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
    localparam int LOAD_N = IMG_N + WGT_N + OUT_CHANNELS;

    localparam int LDW = clog2_min1(LOAD_N);
    localparam int IAW = clog2_min1(IMG_N);
    localparam int WAW = clog2_min1(WGT_N);
    localparam int FW  = clog2_min1(OUT_CHANNELS);
    localparam int CW  = clog2_min1(IN_CHANNELS);
    localparam int KW  = clog2_min1(KERNEL_SIZE);
    localparam int OW  = clog2_min1(OUT_IMG_SIZE);
    localparam int PW  = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Storage (not reset)
    logic [DATA_WIDTH-1:0] img_ram  [IMG_N];
    logic [DATA_WIDTH-1:0] wgt_ram  [WGT_N];
    logic [DATA_WIDTH-1:0] bias_ram [OUT_CHANNELS];

    // Control and registered outputs
    state_t                state_q;
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic [LDW-1:0]        ld_cnt_q;

    // Issue counters: pixel (filter, row, col) and term (channel, krow, kcol)
    logic [FW-1:0] filt_q;
    logic [OW-1:0] row_q;
    logic [OW-1:0] col_q;
    logic [CW-1:0] ch_q;
    logic [KW-1:0] kr_q;
    logic [KW-1:0] kc_q;
    logic          wait_q;        // pixel fully issued, waiting for its result to be accepted
    logic          all_issued_q;  // final pixel issued, nothing more to start

    // F stage
    logic signed [DATA_WIDTH-1:0] pix_q;
    logic signed [DATA_WIDTH-1:0] wgt_q;
    logic                         f_vld_q, f_first_q, f_last_q, f_final_q;
    logic [FW-1:0]                f_filt_q;
    // M stage
    logic signed [PW-1:0]         prod_q;
    logic                         m_vld_q, m_first_q, m_last_q, m_final_q;
    logic [FW-1:0]                m_filt_q;
    // A stage
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic                         a_vld_q, a_final_q;
    logic [FW-1:0]                a_filt_q;

    // Combinational helpers
    logic                         out_hs;
    logic                         issue_en;
    logic                         term_first;
    logic                         term_last;
    logic                         pix_final;
    logic [IAW-1:0]               img_addr;
    logic [WAW-1:0]               wgt_addr;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic [DATA_WIDTH-1:0]        bias_word;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  sum_v;
    logic signed [ACC_WIDTH-1:0]  shift_v;
    logic [DATA_WIDTH-1:0]        res_v;

    assign out_hs = out_valid_q && out_ready;

    // Issue resumes in the very cycle the held sample is accepted, so that
    // with no backpressure the pixel period is exactly T+3 cycles.
    assign issue_en = (state_q == S_COMPUTE) && !all_issued_q && (!wait_q || out_hs);

    assign term_first = (ch_q == '0) && (kr_q == '0) && (kc_q == '0);
    assign term_last  = (ch_q == CW'(IN_CHANNELS-1)) && (kr_q == KW'(KERNEL_SIZE-1))
                        && (kc_q == KW'(KERNEL_SIZE-1));
    assign pix_final  = (filt_q == FW'(OUT_CHANNELS-1)) && (row_q == OW'(OUT_IMG_SIZE-1))
                        && (col_q == OW'(OUT_IMG_SIZE-1));

    assign img_addr = IAW'(int'(ch_q) * IN_IMG_SIZE * IN_IMG_SIZE
                           + (int'(row_q) * STRIDE + int'(kr_q)) * IN_IMG_SIZE
                           + int'(col_q) * STRIDE + int'(kc_q));
    assign wgt_addr = WAW'(((int'(filt_q) * IN_CHANNELS + int'(ch_q)) * KERNEL_SIZE
                            + int'(kr_q)) * KERNEL_SIZE + int'(kc_q));

    assign prod_ext  = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    assign bias_word = bias_ram[a_filt_q];

    // Bias is aligned to the product's 2*FRAC_BITS scale before the add,
    // then the sum is shifted back to FRAC_BITS.
    always_comb begin
        bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_word[DATA_WIDTH-1]}}, bias_word};
        sum_v    = acc_q + (bias_ext <<< FRAC_BITS);
        shift_v  = sum_v >>> FRAC_BITS;
        if (RELU_EN != 0 && shift_v < 0) begin
            shift_v = '0;
        end
        if (shift_v > SAT_MAX) begin
            res_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shift_v < SAT_MIN) begin
            res_v = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            res_v = shift_v[DATA_WIDTH-1:0];
        end
    end

    // Input RAM writes: image, then weights, then biases by beat count.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready_q) begin
            if (ld_cnt_q < LDW'(IMG_N)) begin
                img_ram[IAW'(ld_cnt_q)] <= in_data;
            end else if (ld_cnt_q < LDW'(IMG_N + WGT_N)) begin
                wgt_ram[WAW'(ld_cnt_q - LDW'(IMG_N))] <= in_data;
            end else begin
                bias_ram[FW'(ld_cnt_q - LDW'(IMG_N + WGT_N))] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            ld_cnt_q     <= '0;
            filt_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            ch_q         <= '0;
            kr_q         <= '0;
            kc_q         <= '0;
            wait_q       <= 1'b0;
            all_issued_q <= 1'b0;
            pix_q        <= '0;
            wgt_q        <= '0;
            f_vld_q      <= 1'b0;
            f_first_q    <= 1'b0;
            f_last_q     <= 1'b0;
            f_final_q    <= 1'b0;
            f_filt_q     <= '0;
            prod_q       <= '0;
            m_vld_q      <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_final_q    <= 1'b0;
            m_filt_q     <= '0;
            acc_q        <= '0;
            a_vld_q      <= 1'b0;
            a_final_q    <= 1'b0;
            a_filt_q     <= '0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        ld_cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        if (ld_cnt_q == LDW'(LOAD_N-1)) begin
                            state_q      <= S_COMPUTE;
                            in_ready_q   <= 1'b0;
                            ld_cnt_q     <= '0;
                            filt_q       <= '0;
                            row_q        <= '0;
                            col_q        <= '0;
                            ch_q         <= '0;
                            kr_q         <= '0;
                            kc_q         <= '0;
                            wait_q       <= 1'b0;
                            all_issued_q <= 1'b0;
                        end else begin
                            ld_cnt_q <= ld_cnt_q + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (out_hs && out_last_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase

            // Issue: step kcol, krow, channel; on the last term step the pixel.
            if (out_hs) begin
                wait_q <= 1'b0;
            end
            if (issue_en) begin
                if (term_last) begin
                    ch_q   <= '0;
                    kr_q   <= '0;
                    kc_q   <= '0;
                    wait_q <= 1'b1;
                    if (pix_final) begin
                        all_issued_q <= 1'b1;
                    end else if (col_q != OW'(OUT_IMG_SIZE-1)) begin
                        col_q <= col_q + 1'b1;
                    end else begin
                        col_q <= '0;
                        if (row_q != OW'(OUT_IMG_SIZE-1)) begin
                            row_q <= row_q + 1'b1;
                        end else begin
                            row_q  <= '0;
                            filt_q <= filt_q + 1'b1;
                        end
                    end
                end else if (kc_q != KW'(KERNEL_SIZE-1)) begin
                    kc_q <= kc_q + 1'b1;
                end else begin
                    kc_q <= '0;
                    if (kr_q != KW'(KERNEL_SIZE-1)) begin
                        kr_q <= kr_q + 1'b1;
                    end else begin
                        kr_q <= '0;
                        ch_q <= ch_q + 1'b1;
                    end
                end
            end

            // F: fetch operands, tag the term position and owning filter.
            f_vld_q <= issue_en;
            if (issue_en) begin
                pix_q     <= img_ram[img_addr];
                wgt_q     <= wgt_ram[wgt_addr];
                f_first_q <= term_first;
                f_last_q  <= term_last;
                f_final_q <= pix_final;
                f_filt_q  <= filt_q;
            end

            // M: full-precision product.
            m_vld_q <= f_vld_q;
            if (f_vld_q) begin
                prod_q    <= PW'(pix_q) * PW'(wgt_q);
                m_first_q <= f_first_q;
                m_last_q  <= f_last_q;
                m_final_q <= f_final_q;
                m_filt_q  <= f_filt_q;
            end

            // A: first term of a pixel overwrites the accumulator.
            a_vld_q <= m_vld_q && m_last_q;
            if (m_vld_q) begin
                acc_q     <= m_first_q ? prod_ext : acc_q + prod_ext;
                a_final_q <= m_final_q;
                a_filt_q  <= m_filt_q;
            end

            // Output register: one entry, held until accepted.
            if (a_vld_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_v;
                out_last_q  <= a_final_q;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_layer_stream.sv
// -----------------------------------------------------------------------------
// tb_conv_layer_stream
//
// Bench for conv_layer_stream. Instance 0 uses default parameters; instance 1
// uses STRIDE=2 with ReLU disabled. Constant-valued vectors come from a table
// of hand-derived results; random images are checked against a direct
// convolution model.
// -----------------------------------------------------------------------------
module tb_conv_layer_stream;

    localparam int DW     = 16;
    localparam int NCH    = 2;
    localparam int NF     = 3;
    localparam int ISZ    = 12;
    localparam int KSZ    = 3;
    localparam int T      = NCH * KSZ * KSZ;
    localparam int IMG_N  = NCH * ISZ * ISZ;
    localparam int WGT_N  = NF * NCH * KSZ * KSZ;
    localparam int LOAD_N = IMG_N + WGT_N + NF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic          start     [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] in_data   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [DW-1:0] out_data  [2];
    logic          out_last  [2];
    logic          busy      [2];
    logic          done      [2];
    logic [1:0]    dbg_state [2];

    conv_layer_stream u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0]), .done(done[0]), .dbg_state(dbg_state[0])
    );

    conv_layer_stream #(.STRIDE(2), .RELU_EN(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1]), .done(done[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] img_mem  [IMG_N];
    logic [DW-1:0] wgt_mem  [WGT_N];
    logic [DW-1:0] bias_mem [NF];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int stride_of(input int s);
        return (s == 0) ? 1 : 2;
    endfunction

    function automatic int osz_of(input int s);
        return (ISZ - KSZ) / stride_of(s) + 1;
    endfunction

    function automatic logic [DW-1:0] beat(input int idx);
        if (idx < IMG_N) return img_mem[idx];
        if (idx < IMG_N + WGT_N) return wgt_mem[idx - IMG_N];
        return bias_mem[idx - IMG_N - WGT_N];
    endfunction

    // Direct convolution over real-valued fixed-point numbers.
    task automatic build_model(input int s);
        int st, o;
        longint sum, r;
        exp_q.delete();
        st = stride_of(s);
        o  = osz_of(s);
        for (int f = 0; f < NF; f++)
            for (int y = 0; y < o; y++)
                for (int x = 0; x < o; x++) begin
                    sum = 0;
                    for (int c = 0; c < NCH; c++)
                        for (int ky = 0; ky < KSZ; ky++)
                            for (int kx = 0; kx < KSZ; kx++)
                                sum += longint'($signed(img_mem[c*ISZ*ISZ + (y*st+ky)*ISZ + x*st+kx]))
                                     * longint'($signed(wgt_mem[((f*NCH+c)*KSZ+ky)*KSZ+kx]));
                    sum += longint'($signed(bias_mem[f])) * 8192;
                    r = sum >>> 13;
                    if (s == 0 && r < 0) r = 0;
                    if (r > 32767) r = 32767;
                    if (r < -32768) r = -32768;
                    exp_q.push_back(DW'(r));
                end
    endtask

    task automatic build_table_exp(input int s, input logic [DW-1:0] e0, e1, e2);
        int o = osz_of(s);
        exp_q.delete();
        for (int i = 0; i < o*o; i++) exp_q.push_back(e0);
        for (int i = 0; i < o*o; i++) exp_q.push_back(e1);
        for (int i = 0; i < o*o; i++) exp_q.push_back(e2);
    endtask

    task automatic fill_const(input logic [DW-1:0] iv, wv, b0, b1, b2);
        for (int i = 0; i < IMG_N; i++) img_mem[i] = iv;
        for (int i = 0; i < WGT_N; i++) wgt_mem[i] = wv;
        bias_mem[0] = b0; bias_mem[1] = b1; bias_mem[2] = b2;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < IMG_N; i++) img_mem[i] = DW'(int'($urandom_range(0, 16383)) - 8192);
        for (int i = 0; i < WGT_N; i++) wgt_mem[i] = DW'(int'($urandom_range(0, 8191)) - 4096);
        for (int i = 0; i < NF; i++) bias_mem[i] = DW'(int'($urandom_range(0, 32767)) - 16384);
    endtask

    task automatic check_reset_vals(input int s, input string tag);
        check({tag, "_in_ready"}, in_ready[s], 0);
        check({tag, "_out_valid"}, out_valid[s], 0);
        check({tag, "_out_data"}, out_data[s], 0);
        check({tag, "_out_last"}, out_last[s], 0);
        check({tag, "_busy"}, busy[s], 0);
        check({tag, "_done"}, done[s], 0);
        check({tag, "_state"}, dbg_state[s], 0);
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the negedge of the first COMPUTE cycle.
    task automatic load_phase(input int s, input int gap_pct);
        int idx = 0;
        int guard = 0;
        bit v_prev = 0;
        bit r_prev = 0;
        bit v;
        @(negedge clk); start[s] = 1'b1;
        @(negedge clk); start[s] = 1'b0;
        check("load_in_ready", in_ready[s], 1);
        check("load_busy", busy[s], 1);
        while (1) begin
            if (v_prev && r_prev) idx++;
            if (idx == LOAD_N) break;
            if (guard > 5000) begin
                check("load_timeout", idx, LOAD_N);
                break;
            end
            v = ($urandom_range(0, 99) >= gap_pct);
            in_valid[s] = v;
            in_data[s]  = v ? beat(idx) : DW'($urandom);
            r_prev = in_ready[s];
            v_prev = v;
            @(negedge clk);
            guard++;
        end
        in_valid[s] = 1'b0;
        check("compute_in_ready", in_ready[s], 0);
        check("compute_state", dbg_state[s], 2);
    endtask

    task automatic drain_phase(input int s, input int stall_at, input int stall_len,
                               input int bp_pct, input int poke_cyc, input bit chk_timing);
        int total = NF * osz_of(s) * osz_of(s);
        int n_out = 0;
        int cyc = 0;
        int last_cyc = 0;
        int stall_cnt = 0;
        bit hold = 0;
        bit fin = 0;
        bit rdy;
        logic [DW-1:0] held = '0;
        logic [DW-1:0] e;
        while (!fin && cyc < 20000) begin
            if (hold) begin
                check("hold_valid", out_valid[s], 1);
                check("hold_data", out_data[s], held);
            end
            if (out_valid[s] && !hold && chk_timing) begin
                if (n_out == 0) check("first_latency", cyc, T + 3);
                else check("spacing", cyc - last_cyc, T + 3);
                last_cyc = cyc;
            end
            start[s] = (cyc == poke_cyc);
            if (out_valid[s]) begin
                rdy = 1'b1;
                if (n_out == stall_at && stall_cnt < stall_len) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end else if (int'($urandom_range(0, 99)) < bp_pct) begin
                    rdy = 1'b0;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            out_ready[s] = rdy;
            if (out_valid[s] && rdy) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check($sformatf("sample%0d", n_out), out_data[s], e);
                check($sformatf("last%0d", n_out), out_last[s], (n_out == total - 1));
                n_out++;
                hold = 0;
                if (n_out == total) fin = 1;
            end else if (out_valid[s]) begin
                hold = 1;
                held = out_data[s];
            end else begin
                hold = 0;
            end
            @(negedge clk);
            cyc++;
        end
        start[s] = 1'b0;
        out_ready[s] = 1'b0;
        check("sample_count", n_out, total);
        check("done_pulse", done[s], 1);
        check("done_state", dbg_state[s], 3);
        check("done_out_valid", out_valid[s], 0);
        @(negedge clk);
        check("after_done", done[s], 0);
        check("idle_busy", busy[s], 0);
        check("idle_state", dbg_state[s], 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            inst;
        int            gap;
        bit            timing;
        logic [DW-1:0] img, wgt, b0, b1, b2;
        logic [DW-1:0] e0, e1, e2;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 0,  1'b1, 16'h0400, 16'h2000, 16'h0000, 16'h2000, 16'hA000, 16'h4800, 16'h6800, 16'h0000};
        tbl[1] = '{0, 20, 1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[2] = '{0, 20, 1'b0, 16'h0400, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[3] = '{1, 0,  1'b1, 16'h0400, 16'h2000, 16'h0000, 16'h2000, 16'hA000, 16'h4800, 16'h6800, 16'hE800};
        tbl[4] = '{1, 20, 1'b0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000};
        tbl[5] = '{1, 20, 1'b0, 16'h0400, 16'h2000, 16'h6000, 16'hE000, 16'h0000, 16'h7FFF, 16'h2800, 16'h4800};

        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; in_valid[s] = 1'b0; in_data[s] = '0; out_ready[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_reset_vals(0, "rst0");
        check_reset_vals(1, "rst1");
        reset_n = 1'b1;
        @(negedge clk);

        // Constant-valued vectors with hand-derived results
        for (int i = 0; i < 6; i++) begin
            fill_const(tbl[i].img, tbl[i].wgt, tbl[i].b0, tbl[i].b1, tbl[i].b2);
            build_table_exp(tbl[i].inst, tbl[i].e0, tbl[i].e1, tbl[i].e2);
            load_phase(tbl[i].inst, tbl[i].gap);
            drain_phase(tbl[i].inst, -1, 0, 0, -1, tbl[i].timing);
        end

        // Random data, 50-cycle stall at sample 5, input gaps
        fill_rand();
        build_model(0);
        load_phase(0, 30);
        drain_phase(0, 5, 50, 0, -1, 1'b0);

        // Random data, random backpressure, start pulse mid-compute
        fill_rand();
        build_model(0);
        load_phase(0, 10);
        drain_phase(0, -1, 0, 25, 40, 1'b0);

        // Stride-2 instance, image value = column index << 13
        for (int c = 0; c < NCH; c++)
            for (int y = 0; y < ISZ; y++)
                for (int x = 0; x < ISZ; x++)
                    img_mem[c*ISZ*ISZ + y*ISZ + x] = DW'(x << 13);
        for (int i = 0; i < WGT_N; i++) wgt_mem[i] = 16'h2000;
        for (int i = 0; i < NF; i++) bias_mem[i] = 16'h0000;
        build_model(1);
        load_phase(1, 0);
        drain_phase(1, -1, 0, 0, -1, 1'b1);

        // Stride-2 instance, random data with stalls
        fill_rand();
        build_model(1);
        load_phase(1, 30);
        drain_phase(1, 2, 10, 20, -1, 1'b0);

        // Abort mid-compute by reset, then a full rerun
        fill_rand();
        build_model(0);
        load_phase(0, 0);
        out_ready[0] = 1'b1;
        repeat (30) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("poke_ignored_state", dbg_state[0], 2);
        check("poke_ignored_busy", busy[0], 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals(0, "abort");
        out_ready[0] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        load_phase(0, 15);
        drain_phase(0, -1, 0, 0, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
